// File: rtl/sfq_merge_pulse_monitor_pkg.sv
// Shared constants, event record and helpers for the SFQ merge pulse monitor.
// The event record width follows TS_W_DEF; the top-level TS_W must match it.
package sfq_mon_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int TS_W_DEF        = 16;
    localparam int CNT_W_DEF       = 16;
    localparam int MIN_SEP_DEF     = 3;
    localparam int FIFO_DEPTH_DEF  = 4;

    typedef struct packed {
        logic [TS_W_DEF-1:0] tstamp;
        logic                close;
    } sfq_evt_t;

    localparam sfq_evt_t EVT_NONE = {{TS_W_DEF{1'b0}}, 1'b0};

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
        logic [31:0] result;
        if (value >= limit) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sfq_merge_pulse_monitor_if.sv
// Event readout channel: valid/ready handshake carrying the head event.
interface sfq_merge_pulse_monitor_if
    import sfq_mon_pkg::*;
#(
    parameter int TS_W = TS_W_DEF
);
    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_time;
    logic            evt_close;

    modport master (output evt_valid, output evt_time, output evt_close, input evt_ready);
    modport slave  (input evt_valid, input evt_time, input evt_close, output evt_ready);
endinterface

// File: rtl/sfq_merge_pulse_monitor_fifo.sv
// Synchronous event FIFO with a registered head. The head register is loaded
// with the post-update head each edge, so it always matches valid without extra latency.
module sfq_mon_fifo
    import sfq_mon_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     push,
    input  logic     pop,
    input  sfq_evt_t wdata,
    output logic     valid,
    output sfq_evt_t head,
    output logic     drop
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR0_C  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR1_C  = AW'(1'b1);

    sfq_evt_t      mem_r [DEPTH];
    sfq_evt_t      head_r;
    sfq_evt_t      head_next_s;
    logic          valid_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic [AW-1:0] rd_r;
    logic [AW-1:0] wr_r;
    logic [AW-1:0] rd_inc_s;
    logic          pop_s;
    logic          full_s;
    logic          wr_en_s;
    logic          drop_s;

    // Push/pop qualification, occupancy and next head selection
    always_comb begin
        pop_s        = pop & valid_r;
        full_s       = (count_r == DEPTH_C);
        wr_en_s      = push & (~full_s | pop_s);
        drop_s       = push & full_s & ~pop_s;
        rd_inc_s     = rd_r + PTR1_C;
        count_next_s = count_r + (wr_en_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C);
        head_next_s  = head_r;
        if (count_next_s == ZERO_C) begin
            head_next_s = head_r;
        end else if ((count_r == ZERO_C) || (pop_s && (count_r == ONE_C))) begin
            head_next_s = wdata;
        end else if (pop_s) begin
            head_next_s = mem_r[rd_inc_s];
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage, pointers and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= EVT_NONE;
            end
            head_r  <= EVT_NONE;
            valid_r <= 1'b0;
            count_r <= ZERO_C;
            rd_r    <= PTR0_C;
            wr_r    <= PTR0_C;
        end else if (clr) begin
            head_r  <= EVT_NONE;
            valid_r <= 1'b0;
            count_r <= ZERO_C;
            rd_r    <= PTR0_C;
            wr_r    <= PTR0_C;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_r] <= wdata;
                wr_r        <= wr_r + PTR1_C;
            end
            if (pop_s) begin
                rd_r <= rd_inc_s;
            end
            head_r  <= head_next_s;
            valid_r <= (count_next_s != ZERO_C);
            count_r <= count_next_s;
        end
    end

    assign valid = valid_r;
    assign head  = head_r;
    assign drop  = drop_s;

endmodule

// File: rtl/sfq_merge_pulse_monitor.sv
// Toggle-encoded SFQ pulse monitor: synchronise, timestamp, count, flag close pulses, queue events.
// Optional macro SFQ_MON_MINGAP_EN adds the min_gap output (smallest inter-pulse gap).
module sfq_merge_pulse_monitor
    import sfq_mon_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TS_W        = TS_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MIN_SEP     = MIN_SEP_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           q_in,
    input  logic                           clear,
    sfq_merge_pulse_monitor_if.master      evt,
    output logic                           evt_ovf,
    output logic [CNT_W-1:0]               pulse_count,
    output logic                           viol,
`ifdef SFQ_MON_MINGAP_EN
    output logic [TS_W-1:0]                min_gap,
`endif
    output logic [CNT_W-1:0]               viol_count
);
    localparam int               GAP_W     = $clog2(MIN_SEP + 1);
    localparam logic [GAP_W-1:0] MIN_SEP_C = GAP_W'(MIN_SEP);
    localparam logic [GAP_W-1:0] GAP0_C    = {GAP_W{1'b0}};
    localparam logic [TS_W-1:0]  TS0_C     = {TS_W{1'b0}};
    localparam logic [TS_W-1:0]  TS1_C     = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT0_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT1_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   edge_s;
    logic                   pulse_s;
    logic                   close_s;
    logic [TS_W-1:0]        ts_r;
    logic [GAP_W-1:0]       gap_r;
    logic                   seen_r;
    logic [CNT_W-1:0]       pulse_count_r;
    logic [CNT_W-1:0]       viol_count_r;
    logic                   viol_r;
    logic                   ovf_r;
    logic                   drop_s;
    logic                   fifo_valid_s;
    sfq_evt_t               fifo_head_s;
    sfq_evt_t               evt_s;

    // Input synchroniser and previous-level register; clear leaves them alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], q_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Pulse detection and separation check
    always_comb begin
        edge_s  = sync_r[SYNC_STAGES-1] ^ prev_r;
        pulse_s = edge_s & ~clear;
        close_s = 1'b0;
        if (pulse_s && seen_r && (gap_r < MIN_SEP_C)) begin
            close_s = 1'b1;
        end else begin
            close_s = 1'b0;
        end
        evt_s.tstamp = ts_r;
        evt_s.close  = close_s;
    end

    // Timestamp, gap tracking, counters and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r          <= TS0_C;
            gap_r         <= GAP0_C;
            seen_r        <= 1'b0;
            pulse_count_r <= CNT0_C;
            viol_count_r  <= CNT0_C;
            viol_r        <= 1'b0;
            ovf_r         <= 1'b0;
        end else if (clear) begin
            ts_r          <= TS0_C;
            gap_r         <= GAP0_C;
            seen_r        <= 1'b0;
            pulse_count_r <= CNT0_C;
            viol_count_r  <= CNT0_C;
            viol_r        <= 1'b0;
            ovf_r         <= 1'b0;
        end else begin
            ts_r <= ts_r + TS1_C;
            if (pulse_s) begin
                gap_r         <= GAP0_C;
                seen_r        <= 1'b1;
                pulse_count_r <= pulse_count_r + CNT1_C;
            end else begin
                gap_r <= GAP_W'(sat_inc(32'(gap_r), 32'(MIN_SEP_C)));
            end
            if (close_s) begin
                viol_r       <= 1'b1;
                viol_count_r <= CNT_W'(sat_inc(32'(viol_count_r), 32'(CNT_MAX_C)));
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

`ifdef SFQ_MON_MINGAP_EN
    logic [TS_W-1:0] last_ts_r;
    logic [TS_W-1:0] min_gap_r;
    logic [TS_W-1:0] cur_gap_s;

    // Exact gap since the previous pulse, from the timestamp difference
    always_comb begin
        cur_gap_s = ts_r - last_ts_r;
    end

    // Smallest observed inter-pulse gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ts_r <= TS0_C;
            min_gap_r <= {TS_W{1'b1}};
        end else if (clear) begin
            last_ts_r <= TS0_C;
            min_gap_r <= {TS_W{1'b1}};
        end else if (pulse_s) begin
            last_ts_r <= ts_r;
            if (seen_r && (cur_gap_s < min_gap_r)) begin
                min_gap_r <= cur_gap_s;
            end
        end
    end

    assign min_gap = min_gap_r;
`endif

    sfq_mon_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .push  (pulse_s),
        .pop   (evt.evt_ready),
        .wdata (evt_s),
        .valid (fifo_valid_s),
        .head  (fifo_head_s),
        .drop  (drop_s)
    );

    assign evt.evt_valid = fifo_valid_s;
    assign evt.evt_time  = fifo_head_s.tstamp;
    assign evt.evt_close = fifo_head_s.close;
    assign evt_ovf       = ovf_r;
    assign pulse_count   = pulse_count_r;
    assign viol          = viol_r;
    assign viol_count    = viol_count_r;

endmodule

// File: tb/tb_sfq_merge_pulse_monitor.sv
// Directed plus randomized bench for sfq_merge_pulse_monitor against a sample-history reference model.
module tb_sfq_merge_pulse_monitor;
    import sfq_mon_pkg::*;

    localparam int S     = 2;
    localparam int DEPTH = 4;
    localparam int MSEP  = 3;
    localparam int TSW   = 16;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic q_in;
    logic clear;
    logic evt_ovf;
    logic viol;
    logic [CW-1:0] pulse_count;
    logic [CW-1:0] viol_count;
`ifdef SFQ_MON_MINGAP_EN
    logic [TSW-1:0] min_gap;
`endif

    always #5 clk = ~clk;

    sfq_merge_pulse_monitor_if #(.TS_W(TSW)) evt_if ();

    sfq_merge_pulse_monitor #(
        .SYNC_STAGES (S),
        .TS_W        (TSW),
        .CNT_W       (CW),
        .MIN_SEP     (MSEP),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .q_in        (q_in),
        .clear       (clear),
        .evt         (evt_if),
        .evt_ovf     (evt_ovf),
        .pulse_count (pulse_count),
        .viol        (viol),
`ifdef SFQ_MON_MINGAP_EN
        .min_gap     (min_gap),
`endif
        .viol_count  (viol_count)
    );

    typedef struct {
        int t;
        bit c;
    } mevt_t;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc;
    bit    hist[$];
    mevt_t mq[$];
    int    m_ts, m_pc, m_vc, m_last;
    bit    m_ovf, m_viol, m_seen;
    bit    qv;
    int    got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 1; i++) hist.push_back(1'b0);
        mq.delete();
        cyc = 0; m_ts = 0; m_pc = 0; m_vc = 0; m_last = 0;
        m_ovf = 1'b0; m_viol = 1'b0; m_seen = 1'b0;
    endtask

    // One clock edge of the reference: a pulse is a level change between samples S edges old.
    task automatic model_edge(input bit q, input bit clr, input bit rdy);
        bit pulse, pop, full, close;
        hist.push_back(q);
        if (hist.size() > S + 2) void'(hist.pop_front());
        pulse = (hist[1] != hist[0]);
        pop   = (mq.size() != 0) && rdy;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0; m_viol = 1'b0; m_seen = 1'b0;
            m_pc = 0; m_vc = 0; m_ts = 0;
        end else begin
            close = 1'b0;
            if (pulse) begin
                m_pc = (m_pc + 1) % 65536;
                if (m_seen && (cyc - m_last <= MSEP)) begin
                    close  = 1'b1;
                    m_viol = 1'b1;
                    if (m_vc < 65535) m_vc++;
                end
                m_seen = 1'b1;
                m_last = cyc;
            end
            full = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (pulse) begin
                if (full && !pop) m_ovf = 1'b1;
                else mq.push_back('{t: m_ts, c: close});
            end
            m_ts = (m_ts + 1) % 65536;
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("evt_valid", 32'(evt_if.evt_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("evt_time", 32'(evt_if.evt_time), 32'(mq[0].t));
            chk("evt_close", 32'(evt_if.evt_close), 32'(mq[0].c));
        end
        chk("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
        chk("pulse_count", 32'(pulse_count), 32'(m_pc));
        chk("viol", 32'(viol), 32'(m_viol));
        chk("viol_count", 32'(viol_count), 32'(m_vc));
    endtask

    // Drive one cycle's inputs, advance model at the edge, compare at the falling edge.
    task automatic step(input bit q, input bit clr, input bit rdy);
        q_in = q;
        clear = clr;
        evt_if.evt_ready = rdy;
        @(posedge clk);
        model_edge(q, clr, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(qv, 1'b0, rdy);
    endtask

    task automatic drain(output int cnt);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (evt_if.evt_valid) cnt++;
            step(qv, 1'b0, 1'b1);
        end
    endtask

    task automatic pulse_spaced(input int n);
        for (int k = 0; k < n; k++) begin
            qv = ~qv;
            step(qv, 1'b0, 1'b0);
            run(5, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; q_in = 1'b0; clear = 1'b0; evt_if.evt_ready = 1'b0; qv = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            q_in = ~q_in;
            @(negedge clk);
            chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
            chk("rst_time", 32'(evt_if.evt_time), 32'd0);
            chk("rst_close", 32'(evt_if.evt_close), 32'd0);
            chk("rst_ovf", 32'(evt_ovf), 32'd0);
            chk("rst_pcount", 32'(pulse_count), 32'd0);
            chk("rst_viol", 32'(viol), 32'd0);
            chk("rst_vcount", 32'(viol_count), 32'd0);
        end
        q_in = 1'b0;
        rst_n = 1'b1;

        // Single pulse sampled at the end of cycle 10
        while (cyc < 10) step(1'b0, 1'b0, 1'b0);
        qv = 1'b1;
        step(qv, 1'b0, 1'b0);
        step(qv, 1'b0, 1'b0);
        chk("single_latency", 32'(evt_if.evt_valid), 32'd0);
        step(qv, 1'b0, 1'b0);
        chk("single_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("single_time", 32'(evt_if.evt_time), 32'd12);
        chk("single_pcount", 32'(pulse_count), 32'd1);
        chk("single_viol", 32'(viol), 32'd0);

        // Close pulses two cycles apart after a clear at cycle 15
        while (cyc < 15) step(qv, 1'b0, 1'b0);
        step(qv, 1'b1, 1'b0);
        while (cyc < 20) step(qv, 1'b0, 1'b0);
        qv = 1'b0; step(qv, 1'b0, 1'b0);
        step(qv, 1'b0, 1'b0);
        qv = 1'b1; step(qv, 1'b0, 1'b0);
        run(4, 1'b0);
        chk("close_viol", 32'(viol), 32'd1);
        chk("close_vcount", 32'(viol_count), 32'd1);
        chk("close_pcount", 32'(pulse_count), 32'd2);
        chk("close_first_flag", 32'(evt_if.evt_close), 32'd0);
        step(qv, 1'b0, 1'b1);
        chk("close_second_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("close_second_flag", 32'(evt_if.evt_close), 32'd1);
        chk("close_second_time", 32'(evt_if.evt_time), 32'd8);
        run(3, 1'b1);

        // Overflow: five separated pulses into a four-entry FIFO with no reads
        step(qv, 1'b1, 1'b0);
        pulse_spaced(5);
        chk("ovf_flag", 32'(evt_ovf), 32'd1);
        chk("ovf_pcount", 32'(pulse_count), 32'd5);
        chk("ovf_viol", 32'(viol), 32'd0);
        drain(got);
        chk("ovf_retained", 32'(got), 32'd4);

        // Full FIFO with push and pop in the same detection cycle
        step(qv, 1'b1, 1'b0);
        pulse_spaced(4);
        chk("full_valid", 32'(evt_if.evt_valid), 32'd1);
        qv = ~qv;
        step(qv, 1'b0, 1'b0);
        step(qv, 1'b0, 1'b0);
        step(qv, 1'b0, 1'b1);
        run(3, 1'b0);
        chk("full_pp_ovf", 32'(evt_ovf), 32'd0);
        chk("full_pp_pcount", 32'(pulse_count), 32'd5);
        drain(got);
        chk("full_pp_occupancy", 32'(got), 32'd4);

        // Clear in the detection cycle discards that pulse
        step(qv, 1'b1, 1'b0);
        run(3, 1'b0);
        qv = ~qv;
        step(qv, 1'b0, 1'b0);
        step(qv, 1'b0, 1'b0);
        step(qv, 1'b1, 1'b0);
        chk("clr_pcount", 32'(pulse_count), 32'd0);
        chk("clr_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("clr_viol", 32'(viol), 32'd0);
        run(10, 1'b1);
        chk("clr_no_event", 32'(evt_if.evt_valid), 32'd0);
        chk("clr_no_count", 32'(pulse_count), 32'd0);

        // Randomized traffic: fast bursts, random back-pressure, rare clears
        for (int i = 0; i < 800; i++) begin
            bit clr_r, rdy_r;
            if (i < 200) begin
                if ($urandom_range(0, 1) == 0) qv = ~qv;
                rdy_r = ($urandom_range(0, 3) == 0);
            end else begin
                if ($urandom_range(0, 3) == 0) qv = ~qv;
                rdy_r = ($urandom_range(0, 2) != 0);
            end
            clr_r = ($urandom_range(0, 63) == 0);
            step(qv, clr_r, rdy_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
